// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch slice: instruction width,
// PC increment, NOP encoding, the buffered entry layout and a PC alignment
// helper. Imported by the interface and the fetch unit top.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int                INST_W   = 32;
    localparam logic [31:0]       PC_INC   = 32'd4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    // One instruction buffer entry: fetched word plus the address it came from.
    typedef struct packed {
        logic [INST_W-1:0] data;
        logic [31:0]       pc;
    } fetch_entry_t;

    // Force a PC onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles every handshake/bus signal of the fetch unit:
//   imem_req_*   request channel to instruction memory (valid/ready/addr)
//   imem_resp_*  in-order response channel from memory (never back-pressured)
//   redirect_*   one-cycle control-flow redirect from the back end
//   inst_*       instruction channel to decode (valid/ready/data/pc)
// modport master : the fetch unit side
// modport slave  : the environment (memory + core) side
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [31:0]       imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [31:0]       inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO, DEPTH x WIDTH, with push/pop/flush and an
// occupancy count. The head entry is read straight out of registered
// storage so consumers see no combinational path from push_data.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   flush            empty the FIFO next cycle (wins over push/pop)
//   push, push_data  write an entry (ignored when full)
//   pop              drop the head entry (ignored when empty)
//   head_data        current head entry
//   count            number of valid entries (0..DEPTH)
//   full, empty      count == DEPTH / count == 0
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; entries are only observed once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= push_data;
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Issues word-aligned fetches from fetch_pc,
// tags each accepted request with its PC, buffers in-order responses and
// presents them to decode. A redirect flushes the buffer, retargets
// fetch_pc and discards every response still in flight for the old path.
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     instruction buffer entries = max outstanding requests (2^n, >=2)
// Ports:
//   clk    single clock, all state on the rising edge
//   reset  asynchronous active-high reset
//   bus    fetch_unit_if.master (memory request/response, redirect, decode)
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam int               CNT_W       = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_LIMIT = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W:0]   inflight;
    logic             req_fire;
    logic             deq;
    logic             drop_resp;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_full;
    logic             buf_empty;
    logic             tag_full;
    logic             tag_empty;
    logic [31:0]      resp_pc;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign deq      = bus.inst_valid && bus.inst_ready;

    // Slots already committed: requests in flight plus buffered entries,
    // less the one decode takes this cycle. Keeping this below DEPTH means
    // every response always has a buffer slot waiting for it.
    assign inflight = {1'b0, outstanding} + {1'b0, occupancy}
                    - {{CNT_W{1'b0}}, deq};

    // Gated by reset directly so the request drops the instant reset asserts.
    assign bus.imem_req_valid = !reset && !bus.redirect_valid
                              && (inflight < DEPTH_LIMIT);
    assign bus.imem_req_addr  = fetch_pc_reg;

    // Responses belonging to the abandoned path: anything arriving with a
    // redirect, and the drop_cnt responses still in flight from before it.
    assign drop_resp  = bus.redirect_valid || (drop_cnt_reg != '0);
    assign buf_push   = bus.imem_resp_valid && !drop_resp;
    assign buf_pop    = deq && !bus.redirect_valid;
    assign push_entry = '{data: bus.imem_resp_data, pc: resp_pc};

    // PC tags, one per accepted request, retired by every response
    // (kept or dropped). Its count is the outstanding-request count, and it
    // is never flushed: stale tags drain with the dropped responses.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc_reg),
        .pop       (bus.imem_resp_valid),
        .head_data (resp_pc),
        .count     (outstanding),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (buf_push),
        .push_data (push_entry),
        .pop       (buf_pop),
        .head_data (head_entry),
        .count     (occupancy),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign bus.inst_valid = !buf_empty;
    assign bus.inst_data  = bus.inst_valid ? head_entry.data : '0;
    assign bus.inst_pc    = bus.inst_valid ? head_entry.pc   : '0;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        drop_cnt_next = drop_cnt_reg;
        if (bus.redirect_valid) begin
            fetch_pc_next = align_pc(bus.redirect_pc);
            // Every request still in flight after this cycle is stale.
            drop_cnt_next = outstanding - CNT_W'(bus.imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + PC_INC;
            end
            if (bus.imem_resp_valid && (drop_cnt_reg != '0)) begin
                drop_cnt_next = drop_cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg <= align_pc(RESET_PC);
            drop_cnt_reg <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    a_no_buf_overflow: assert property (@(posedge clk) disable iff (reset)
        !(buf_push && buf_full));
    a_no_tag_overflow: assert property (@(posedge clk) disable iff (reset)
        !(req_fire && tag_full));
    a_no_stray_resp: assert property (@(posedge clk) disable iff (reset)
        !(bus.imem_resp_valid && tag_empty));

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed, table-driven bench for fetch_unit. Each table row gives the
// cycle's inputs and the expected outputs; a behavioural memory returns
// each accepted request after 1 or 2 cycles. A second instance
// (RESET_PC = FFFF_FFF8, DEPTH = 4, no responses) covers PC wrap.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    typedef struct {
        logic        ir;
        logic        rr;
        logic        redir;
        logic [31:0] redir_pc;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } row_t;

    logic clk;
    logic reset;

    fetch_unit_if bus();
    fetch_unit_if bus2();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .DEPTH    (4)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // memory model pipeline
    int          mem_lat = 1;
    logic        p1v = 1'b0, p2v = 1'b0;
    logic [31:0] p1a = '0,   p2a = '0;

    // values observed at the negedge of the last stepped cycle
    logic        o_rv, o_iv, o2_rv;
    logic [31:0] o_addr, o_pc, o_data, o2_addr;

    row_t main_tbl[24];
    row_t red_tbl[9];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic row_t mk(input logic ir, input logic rr, input logic redir,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] ea, input logic eiv,
                                input logic [31:0] epc);
        row_t r;
        r.ir = ir; r.rr = rr; r.redir = redir; r.redir_pc = rpc;
        r.exp_rv = ev; r.exp_addr = ea; r.exp_iv = eiv; r.exp_pc = epc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: sample at negedge, then advance the memory model.
    task automatic step();
        logic acc;
        @(negedge clk);
        o_rv    = bus.imem_req_valid;
        o_addr  = bus.imem_req_addr;
        o_iv    = bus.inst_valid;
        o_pc    = bus.inst_pc;
        o_data  = bus.inst_data;
        o2_rv   = bus2.imem_req_valid;
        o2_addr = bus2.imem_req_addr;
        acc     = bus.imem_req_valid && bus.imem_req_ready;
        @(posedge clk);
        #1;
        if (reset) begin
            p1v = 1'b0;
            p2v = 1'b0;
        end else begin
            p2v = p1v;
            p2a = p1a;
            p1v = acc;
            p1a = o_addr;
        end
        bus.imem_resp_valid = (mem_lat == 2) ? p2v : p1v;
        bus.imem_resp_data  = mem_word((mem_lat == 2) ? p2a : p1a);
    endtask

    task automatic apply_row(input row_t r, input string tag);
        bus.inst_ready     = r.ir;
        bus.imem_req_ready = r.rr;
        bus.redirect_valid = r.redir;
        bus.redirect_pc    = r.redir_pc;
        step();
        $display("%s: req_v=%0b addr=%h inst_v=%0b pc=%h data=%h",
                 tag, o_rv, o_addr, o_iv, o_pc, o_data);
        check($sformatf("%s.req_valid", tag), 32'(o_rv), 32'(r.exp_rv));
        check($sformatf("%s.req_addr", tag), o_addr, r.exp_addr);
        check($sformatf("%s.inst_valid", tag), 32'(o_iv), 32'(r.exp_iv));
        if (r.exp_iv) begin
            check($sformatf("%s.inst_pc", tag), o_pc, r.exp_pc);
            check($sformatf("%s.inst_data", tag), o_data, mem_word(r.exp_pc));
        end
    endtask

    task automatic do_reset(input int lat);
        reset               = 1'b1;
        bus.inst_ready      = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_resp_valid = 1'b0;
        p1v = 1'b0;
        p2v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mem_lat = lat;
        reset   = 1'b0;
    endtask

    initial begin
        logic [31:0] exp2_a[5];
        logic        exp2_v[5];

        exp2_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000,
                   32'h0000_0004, 32'h0000_0008};
        exp2_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        //                ir rr rd rpc        rv addr      iv pc
        main_tbl[0]  = mk(1, 1, 0, 32'h0,     1, 32'h000,  0, 32'h0);
        main_tbl[1]  = mk(1, 1, 0, 32'h0,     1, 32'h004,  0, 32'h0);
        main_tbl[2]  = mk(0, 1, 0, 32'h0,     0, 32'h008,  1, 32'h000);
        main_tbl[3]  = mk(0, 1, 0, 32'h0,     0, 32'h008,  1, 32'h000);
        main_tbl[4]  = mk(0, 1, 0, 32'h0,     0, 32'h008,  1, 32'h000);
        main_tbl[5]  = mk(0, 1, 0, 32'h0,     0, 32'h008,  1, 32'h000);
        main_tbl[6]  = mk(0, 1, 0, 32'h0,     0, 32'h008,  1, 32'h000);
        main_tbl[7]  = mk(1, 1, 0, 32'h0,     1, 32'h008,  1, 32'h000);
        main_tbl[8]  = mk(1, 1, 0, 32'h0,     1, 32'h00C,  1, 32'h004);
        main_tbl[9]  = mk(1, 1, 0, 32'h0,     1, 32'h010,  1, 32'h008);
        main_tbl[10] = mk(1, 1, 0, 32'h0,     1, 32'h014,  1, 32'h00C);
        main_tbl[11] = mk(1, 1, 1, 32'h203,   0, 32'h018,  1, 32'h010);
        main_tbl[12] = mk(1, 1, 0, 32'h0,     1, 32'h200,  0, 32'h0);
        main_tbl[13] = mk(1, 1, 0, 32'h0,     1, 32'h204,  0, 32'h0);
        main_tbl[14] = mk(1, 1, 0, 32'h0,     1, 32'h208,  1, 32'h200);
        main_tbl[15] = mk(1, 1, 0, 32'h0,     1, 32'h20C,  1, 32'h204);
        main_tbl[16] = mk(1, 1, 1, 32'h300,   0, 32'h210,  1, 32'h208);
        main_tbl[17] = mk(1, 1, 1, 32'h400,   0, 32'h300,  0, 32'h0);
        main_tbl[18] = mk(1, 1, 0, 32'h0,     1, 32'h400,  0, 32'h0);
        main_tbl[19] = mk(1, 1, 0, 32'h0,     1, 32'h404,  0, 32'h0);
        main_tbl[20] = mk(1, 1, 0, 32'h0,     1, 32'h408,  1, 32'h400);
        main_tbl[21] = mk(1, 0, 0, 32'h0,     1, 32'h40C,  1, 32'h404);
        main_tbl[22] = mk(0, 0, 0, 32'h0,     1, 32'h40C,  1, 32'h408);
        main_tbl[23] = mk(0, 0, 0, 32'h0,     1, 32'h40C,  1, 32'h408);

        // two-cycle memory: redirect with two requests in flight
        red_tbl[0] = mk(1, 1, 0, 32'h0,   1, 32'h000, 0, 32'h0);
        red_tbl[1] = mk(1, 1, 0, 32'h0,   1, 32'h004, 0, 32'h0);
        red_tbl[2] = mk(1, 1, 1, 32'h100, 0, 32'h008, 0, 32'h0);
        red_tbl[3] = mk(1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        red_tbl[4] = mk(1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        red_tbl[5] = mk(1, 1, 0, 32'h0,   0, 32'h108, 0, 32'h0);
        red_tbl[6] = mk(1, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100);
        red_tbl[7] = mk(1, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h104);
        red_tbl[8] = mk(1, 1, 0, 32'h0,   0, 32'h110, 0, 32'h0);

        // second instance: memory accepts everything, never responds
        bus2.imem_req_ready  = 1'b1;
        bus2.imem_resp_valid = 1'b0;
        bus2.imem_resp_data  = '0;
        bus2.redirect_valid  = 1'b0;
        bus2.redirect_pc     = '0;
        bus2.inst_ready      = 1'b0;
        bus.imem_resp_data   = '0;

        // reset state
        reset               = 1'b1;
        bus.inst_ready      = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("reset: req_v=%0b addr=%h inst_v=%0b", bus.imem_req_valid,
                 bus.imem_req_addr, bus.inst_valid);
        check("rst.req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst.req_addr", bus.imem_req_addr, 32'h0);
        check("rst.inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst.inst_data", bus.inst_data, 32'h0);
        check("rst.inst_pc", bus.inst_pc, 32'h0);
        check("rst.dut2_addr", bus2.imem_req_addr, 32'hFFFF_FFF8);
        check("rst.dut2_req_valid", 32'(bus2.imem_req_valid), 32'd0);
        do_reset(1);

        for (int i = 0; i < 24; i++) begin
            apply_row(main_tbl[i], $sformatf("main[%0d]", i));
        end

        // mid-stall: buffered instruction and pending request both visible,
        // then asynchronous reset must clear outputs without a clock edge
        #2;
        check("stall.pre_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("stall.pre_inst_valid", 32'(bus.inst_valid), 32'd1);
        reset = 1'b1;
        #1;
        $display("async reset: req_v=%0b addr=%h inst_v=%0b pc=%h data=%h",
                 bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid,
                 bus.inst_pc, bus.inst_data);
        check("arst.req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("arst.req_addr", bus.imem_req_addr, 32'h0);
        check("arst.inst_valid", 32'(bus.inst_valid), 32'd0);
        check("arst.inst_data", bus.inst_data, 32'h0);
        check("arst.inst_pc", bus.inst_pc, 32'h0);

        do_reset(2);
        for (int i = 0; i < 9; i++) begin
            apply_row(red_tbl[i], $sformatf("redir[%0d]", i));
            if (i < 5) begin
                $display("wrap[%0d]: req_v=%0b addr=%h", i, o2_rv, o2_addr);
                check($sformatf("wrap[%0d].req_valid", i), 32'(o2_rv), 32'(exp2_v[i]));
                check($sformatf("wrap[%0d].req_addr", i), o2_addr, exp2_a[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
